// File: rtl/ahb_lite_refill_master.sv
// rtl/ahb_lite_refill_master.sv - AHB-Lite read-burst master that refills one I-cache line
// Issues one aligned INCR4/8/16 read burst per miss and returns the assembled line with a one-cycle pulse.
module ahb_lite_refill_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             hclk,
    input  logic                             hrstn,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data,
    output logic                             resp_err,
    output logic [ADDR_WIDTH-1:0]            haddr,
    output logic [1:0]                       htrans,
    output logic                             hwrite,
    output logic [2:0]                       hsize,
    output logic [2:0]                       hburst,
    output logic [3:0]                       hprot,
    output logic [DATA_WIDTH-1:0]            hwdata,
    input  logic [DATA_WIDTH-1:0]            hrdata,
    input  logic                             hready,
    input  logic                             hresp
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0]         LAST      = CW'(LINE_WORDS - 1);
    localparam logic [CW-1:0]         FULL      = CW'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [2:0] BURST = (LINE_WORDS == 16) ? 3'b111 :
                                   (LINE_WORDS == 8)  ? 3'b101 : 3'b011;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_RESP} state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    addr_cnt_q, addr_cnt_d;
    logic [CW-1:0]                    data_cnt_q, data_cnt_d;
    logic [ADDR_WIDTH-1:0]            haddr_q, haddr_d;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q, line_d;
    logic                             err_q, err_d;
    logic                             addr_pending;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q    <= S_IDLE;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
            haddr_q    <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            data_cnt_q <= data_cnt_d;
            haddr_q    <= haddr_d;
            line_q     <= line_d;
            err_q      <= err_d;
        end
    end

    // haddr_q always holds the address on the bus; it only advances when a transfer is accepted.
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        data_cnt_d   = data_cnt_q;
        haddr_d      = haddr_q;
        line_d       = line_q;
        err_d        = err_q;
        htrans       = HT_IDLE;
        hburst       = 3'b001;
        addr_pending = (addr_cnt_q < FULL);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    haddr_d    = req_addr & ~OFFS_MASK;
                    addr_cnt_d = '0;
                    data_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                htrans = HT_NONSEQ;
                hburst = BURST;
                if (hready) begin
                    addr_cnt_d = CW'(1);
                    haddr_d    = haddr_q + WORD_STEP;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                hburst = BURST;
                if (addr_pending) begin
                    htrans = HT_SEQ;
                end
                if (hready) begin
                    if (hresp) begin
                        // ERROR without its first wait cycle: close out the line as failed.
                        line_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        line_d[data_cnt_q[IW-1:0]*DATA_WIDTH +: DATA_WIDTH] = hrdata;
                        data_cnt_d = data_cnt_q + CW'(1);
                        if (addr_pending) begin
                            addr_cnt_d = addr_cnt_q + CW'(1);
                            if (addr_cnt_q != LAST) begin
                                haddr_d = haddr_q + WORD_STEP;
                            end
                        end
                        if (data_cnt_q == LAST) begin
                            state_d = S_RESP;
                        end
                    end
                end else if (hresp) begin
                    line_d  = '0;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (hready) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = line_q;
    assign resp_err   = err_q;
    assign haddr      = haddr_q;
    assign hwrite     = 1'b0;
    assign hsize      = 3'b010;
    assign hprot      = 4'b0010;
    assign hwdata     = '0;

endmodule

// File: tb/tb_ahb_lite_refill_master.sv
// tb/tb_ahb_lite_refill_master.sv - self-checking bench for the AHB-Lite line refill master
module tb_ahb_lite_refill_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int N8 = 8;
    localparam int LW = N * DW;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] base;
        logic [DW-1:0] dbase;
        int            wait_idx;
        int            wait_n;
        int            err_idx;
        int            lat;
        logic          err;
    } vec_t;

    typedef struct {
        logic [LW-1:0] data;
        logic          err;
        int            lat;
    } resp_t;

    logic           hclk;
    logic           hrstn;
    logic           req_valid, req_ready, resp_valid, resp_err;
    logic [AW-1:0]  req_addr, haddr;
    logic [LW-1:0]  resp_data;
    logic [1:0]     htrans;
    logic           hwrite, hready, hresp;
    logic [2:0]     hsize, hburst;
    logic [3:0]     hprot;
    logic [DW-1:0]  hwdata, hrdata;

    logic             req_valid8, req_ready8, resp_valid8, resp_err8;
    logic [AW-1:0]    req_addr8, haddr8;
    logic [N8*DW-1:0] resp_data8;
    logic [1:0]       htrans8;
    logic             hwrite8, hready8, hresp8;
    logic [2:0]       hsize8, hburst8;
    logic [3:0]       hprot8;
    logic [DW-1:0]    hwdata8, hrdata8;

    ahb_lite_refill_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(N)) u_dut (
        .hclk(hclk), .hrstn(hrstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    ahb_lite_refill_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(N8)) u_dut8 (
        .hclk(hclk), .hrstn(hrstn), .req_valid(req_valid8), .req_ready(req_ready8),
        .req_addr(req_addr8), .resp_valid(resp_valid8), .resp_data(resp_data8), .resp_err(resp_err8),
        .haddr(haddr8), .htrans(htrans8), .hwrite(hwrite8), .hsize(hsize8), .hburst(hburst8),
        .hprot(hprot8), .hwdata(hwdata8), .hrdata(hrdata8), .hready(hready8), .hresp(hresp8)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int            n_checks = 0;
    int            n_fail   = 0;
    vec_t          cur;
    logic          pend;
    logic [AW-1:0] pend_addr;
    int            wait_left;
    logic          err_phase;
    logic [AW-1:0] exp_addr_q[$];
    resp_t         exp_resp_q[$];
    logic [LW-1:0] last_data = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_htrans"}, htrans, HT_IDLE);
        check({tag, "_haddr"}, haddr, 0);
        check({tag, "_hburst"}, hburst, 3'b001);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_ctrl"}, {hwrite, hsize, hprot, hwdata}, {1'b0, 3'b010, 4'b0010, 32'h0});
    endtask

    function automatic int word_idx(input logic [AW-1:0] a);
        return int'((a - cur.base) >> 2);
    endfunction

    // Slave model: ERROR on a chosen data phase, optional wait cycles on a chosen address.
    task automatic slave_drive();
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (pend && word_idx(pend_addr) == cur.err_idx) begin
            hresp  = 1'b1;
            hready = err_phase;
        end else begin
            if (pend) hrdata = cur.dbase + DW'(word_idx(pend_addr));
            if (htrans != HT_IDLE && word_idx(haddr) == cur.wait_idx && wait_left > 0) begin
                hready = 1'b0;
                wait_left--;
            end
        end
    endtask

    task automatic slave_update(input logic [1:0] t, input logic [AW-1:0] a);
        if (hresp && !hready) begin
            err_phase = 1'b1;
        end else if (hready) begin
            err_phase = 1'b0;
            pend      = t[1];
            pend_addr = a;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        resp_t         r;
        int            cyc, n_acc, n_exp;
        bit            done;
        logic [1:0]    s_htrans, p_htrans;
        logic [AW-1:0] s_haddr, p_haddr;
        logic          p_hready, p_hresp;
        cur = v; wait_left = v.wait_n; err_phase = 1'b0; pend = 1'b0; pend_addr = '0;
        n_exp = (v.err_idx < 0) ? N : ((v.err_idx + 1 < N) ? v.err_idx + 1 : N);
        for (int i = 0; i < n_exp; i++) exp_addr_q.push_back(v.base + AW'(4 * i));
        r.data = '0;
        if (!v.err) for (int i = 0; i < N; i++) r.data[i*DW +: DW] = v.dbase + DW'(i);
        r.err = v.err;
        r.lat = v.lat;
        exp_resp_q.push_back(r);

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = v.addr; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        @(posedge hclk);
        @(negedge hclk);
        if (!hold) req_valid = 1'b0;
        cyc = 1; n_acc = 0; done = 0;
        p_hready = 1'b1; p_hresp = 1'b0; p_htrans = HT_IDLE; p_haddr = '0;
        while (!done && cyc <= 64) begin
            if (resp_valid) begin
                r = exp_resp_q.pop_front();
                check("resp_latency", cyc, r.lat);
                check("resp_data", resp_data, r.data);
                check("resp_err", resp_err, r.err);
                check("resp_htrans", htrans, HT_IDLE);
                check("resp_req_ready", req_ready, 0);
                check("addr_count_left", exp_addr_q.size(), 0);
                exp_addr_q.delete();
                last_data = r.data;
                done = 1;
            end else begin
                check("req_ready_busy", req_ready, 0);
                if (htrans != HT_IDLE) check("hburst", hburst, 3'b011);
                if (!p_hready && !p_hresp && p_htrans != HT_IDLE) begin
                    check("hold_haddr", haddr, p_haddr);
                    check("hold_htrans", htrans, p_htrans);
                end
                if (err_phase) check("htrans_err2", htrans, HT_IDLE);
                s_htrans = htrans; s_haddr = haddr;
                slave_drive();
                p_hready = hready; p_hresp = hresp; p_htrans = s_htrans; p_haddr = s_haddr;
                @(posedge hclk);
                if (hready && s_htrans[1]) begin
                    check("htrans_kind", s_htrans, (n_acc == 0) ? HT_NONSEQ : HT_SEQ);
                    if (exp_addr_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL extra_addr: got %0h required none", s_haddr);
                    end else begin
                        check("haddr", s_haddr, exp_addr_q.pop_front());
                    end
                    n_acc++;
                end
                slave_update(s_htrans, s_haddr);
                @(negedge hclk);
                cyc++;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: got no resp_valid required one within 64 cycles");
            exp_addr_q.delete();
            exp_resp_q.delete();
        end
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        @(posedge hclk);
        @(negedge hclk);
        check("resp_pulse_end", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
        check("resp_err_clear", resp_err, 0);
        check("resp_data_hold", resp_data, last_data);
    endtask

    initial begin
        vec_t             vecs[9];
        vec_t             va, vb, vr;
        logic [N8*DW-1:0] exp8;
        logic [1:0]       s8_t;
        logic [AW-1:0]    s8_a;
        int               n8, pidx, cyc8;
        bit               pend8, seen;

        //           req_addr       base           dbase   widx wn  eidx lat err
        vecs[0] = '{32'h0000_1234, 32'h0000_1230, 32'hA0, -1, 0, -1, 6, 1'b0};
        vecs[1] = '{32'h0000_1234, 32'h0000_1230, 32'hB0,  2, 2, -1, 8, 1'b0};
        vecs[2] = '{32'h0000_1234, 32'h0000_1230, 32'hC0, -1, 0,  1, 5, 1'b1};
        vecs[3] = '{32'h0000_2000, 32'h0000_2000, 32'hD0, -1, 0, -1, 6, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hE0, -1, 0, -1, 6, 1'b0};
        vecs[5] = '{32'h0000_03FC, 32'h0000_03F0, 32'h50,  0, 1, -1, 7, 1'b0};
        vecs[6] = '{32'h0000_5678, 32'h0000_5670, 32'h60,  3, 3, -1, 9, 1'b0};
        vecs[7] = '{32'h0000_0100, 32'h0000_0100, 32'h70, -1, 0,  0, 4, 1'b1};
        vecs[8] = '{32'h0000_0200, 32'h0000_0200, 32'h90, -1, 0,  3, 7, 1'b1};
        va      = '{32'h0000_4444, 32'h0000_4440, 32'h11, -1, 0, -1, 6, 1'b0};
        vb      = '{32'h0000_8888, 32'h0000_8880, 32'h22, -1, 0, -1, 6, 1'b0};
        vr      = '{32'h0000_1234, 32'h0000_1230, 32'h33, -1, 0, -1, 6, 1'b0};

        hrstn = 1'b0;
        req_valid = 1'b0; req_addr = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        req_valid8 = 1'b0; req_addr8 = '0; hready8 = 1'b1; hresp8 = 1'b0; hrdata8 = '0;
        #2;
        check_reset("por");
        @(negedge hclk);
        @(negedge hclk);
        hrstn = 1'b1;
        @(negedge hclk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

        // req_valid held high: second request waits for IDLE, bursts back to back
        run_vec(va, 1'b1);
        run_vec(vb, 1'b0);

        // reset after the second address has been accepted
        req_valid = 1'b1; req_addr = 32'h0000_1234; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge hclk);
            @(negedge hclk);
        end
        check("pre_reset_haddr", haddr, 32'h0000_1238);
        check("pre_reset_htrans", htrans, HT_SEQ);
        hrstn = 1'b0;
        #1;
        check_reset("mid");
        @(negedge hclk);
        @(negedge hclk);
        hrstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge hclk);
            if (resp_valid) seen = 1;
        end
        check("no_resp_after_reset", seen, 0);
        last_data = '0;
        run_vec(vr, 1'b0);

        // eight-word line on the second instance, zero wait states
        check("req_ready8_idle", req_ready8, 1);
        req_valid8 = 1'b1; req_addr8 = 32'h0000_03FC;
        @(posedge hclk);
        @(negedge hclk);
        req_valid8 = 1'b0;
        cyc8 = 1; n8 = 0; pend8 = 0; pidx = 0;
        while (!resp_valid8 && cyc8 <= 40) begin
            hrdata8 = pend8 ? DW'(32'h80 + pidx) : '0;
            if (htrans8 != HT_IDLE) check("hburst8", hburst8, 3'b101);
            s8_t = htrans8; s8_a = haddr8;
            @(posedge hclk);
            pend8 = s8_t[1];
            if (s8_t[1]) begin
                check("haddr8", s8_a, 32'h0000_03E0 + AW'(4 * n8));
                pidx = n8;
                n8++;
            end
            @(negedge hclk);
            cyc8++;
        end
        exp8 = '0;
        for (int i = 0; i < N8; i++) exp8[i*DW +: DW] = DW'(32'h80 + i);
        check("resp_valid8", resp_valid8, 1);
        check("resp_latency8", cyc8, 10);
        check("addr_count8", n8, 8);
        check("resp_data8", resp_data8, exp8);
        check("resp_err8", resp_err8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
